cdb_arbiter: RTL and testbench

Completion-side arbiter for the Tomasulo out-of-order core. It collects results from the arithmetic, logic and multiply functional units, buffers them in small per-unit queues, and grants one result per cycle onto the single common data bus (CDB). The granted result is broadcast to reservation stations, the register file and the ROB. Functional units are back-pressured by a valid/ready handshake, and the CDB is never stalled.

---
 rtl/cdb_arbiter.sv | 139 +++++++++++++
 tb/tb_cdb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result queues feeding one registered CDB
// broadcast per cycle, granted round-robin across non-empty queue heads.
module cdb_arbiter #(
  parameter int FU_N    = 3,
  parameter int Q_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [FU_N-1:0]    fu_res_vld,
  output logic [FU_N-1:0]    fu_res_rdy,
  input  logic [FU_N*5-1:0]  fu_res_tag,
  input  logic [FU_N*5-1:0]  fu_res_wa,
  input  logic [FU_N*32-1:0] fu_res_wdata,
  input  logic [FU_N*5-1:0]  fu_res_robid,
  output logic               cdb_vld,
  output logic [4:0]         cdb_tag,
  output logic [4:0]         cdb_wa,
  output logic [31:0]        cdb_wdata,
  output logic [4:0]         cdb_robid,
  output logic [FU_N-1:0]    cdb_grant
);
  localparam int PW  = $clog2(Q_DEPTH) + 1;
  localparam int AW  = PW - 1;
  localparam int RRW = (FU_N > 2) ? $clog2(FU_N) : 1;
  localparam int EW  = 47;

  logic [FU_N-1:0]         empty;
  logic [FU_N-1:0]         full;
  logic [FU_N-1:0][EW-1:0] head;
  logic [FU_N-1:0]         win_onehot;
  logic                    win_found;
  logic [RRW-1:0]          win_idx;
  logic [EW-1:0]           win_entry;
  logic [RRW-1:0]          rr_ptr_reg;
  logic [RRW-1:0]          rr_ptr_next;

  logic                    cdb_vld_reg;
  logic [FU_N-1:0]         cdb_grant_reg;
  logic [4:0]              cdb_tag_reg;
  logic [4:0]              cdb_wa_reg;
  logic [31:0]             cdb_wdata_reg;
  logic [4:0]              cdb_robid_reg;

  // Ready depends only on registered occupancy, so a full queue stays
  // not-ready during the cycle its head is being granted.
  assign fu_res_rdy = ~full;

  for (genvar gi = 0; gi < FU_N; gi++) begin : g_queue
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [EW-1:0] mem [Q_DEPTH];
    logic          enq;
    logic          deq;

    assign enq = fu_res_vld[gi] & fu_res_rdy[gi] & ~flush;
    assign deq = win_onehot[gi] & ~flush;

    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (enq) begin
        mem[wr_ptr_reg[AW-1:0]] <= {fu_res_tag[gi*5 +: 5], fu_res_wa[gi*5 +: 5],
                                    fu_res_wdata[gi*32 +: 32], fu_res_robid[gi*5 +: 5]};
      end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
    assign full[gi]  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head[gi]  = mem[rd_ptr_reg[AW-1:0]];
  end

  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < FU_N; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= FU_N) cand = cand - FU_N;
      if (!win_found && !empty[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[RRW-1:0];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    if (win_found) win_onehot[win_idx] = 1'b1;
  end

  assign win_entry   = head[win_idx];
  assign rr_ptr_next = (win_idx == RRW'(FU_N - 1)) ? '0 : win_idx + RRW'(1);

  // Flush keeps the fairness pointer; only reset returns it to unit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      cdb_vld_reg   <= 1'b0;
      cdb_grant_reg <= '0;
      cdb_tag_reg   <= '0;
      cdb_wa_reg    <= '0;
      cdb_wdata_reg <= '0;
      cdb_robid_reg <= '0;
    end else if (flush) begin
      cdb_vld_reg   <= 1'b0;
      cdb_grant_reg <= '0;
    end else begin
      cdb_vld_reg   <= win_found;
      cdb_grant_reg <= win_onehot;
      if (win_found) begin
        rr_ptr_reg    <= rr_ptr_next;
        cdb_tag_reg   <= win_entry[46:42];
        cdb_wa_reg    <= win_entry[41:37];
        cdb_wdata_reg <= win_entry[36:5];
        cdb_robid_reg <= win_entry[4:0];
      end
    end
  end

  assign cdb_vld   = cdb_vld_reg;
  assign cdb_grant = cdb_grant_reg;
  assign cdb_tag   = cdb_tag_reg;
  assign cdb_wa    = cdb_wa_reg;
  assign cdb_wdata = cdb_wdata_reg;
  assign cdb_robid = cdb_robid_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order,
// back-pressure, pointer wrap, flush and mid-run reset.
module tb_cdb_arbiter;
  localparam int FU_N = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [FU_N-1:0]    fu_res_vld;
  logic [FU_N-1:0]    fu_res_rdy;
  logic [FU_N*5-1:0]  fu_res_tag;
  logic [FU_N*5-1:0]  fu_res_wa;
  logic [FU_N*32-1:0] fu_res_wdata;
  logic [FU_N*5-1:0]  fu_res_robid;
  logic               cdb_vld;
  logic [4:0]         cdb_tag;
  logic [4:0]         cdb_wa;
  logic [31:0]        cdb_wdata;
  logic [4:0]         cdb_robid;
  logic [FU_N-1:0]    cdb_grant;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.FU_N(FU_N), .Q_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fu_res_vld   (fu_res_vld),
    .fu_res_rdy   (fu_res_rdy),
    .fu_res_tag   (fu_res_tag),
    .fu_res_wa    (fu_res_wa),
    .fu_res_wdata (fu_res_wdata),
    .fu_res_robid (fu_res_robid),
    .cdb_vld      (cdb_vld),
    .cdb_tag      (cdb_tag),
    .cdb_wa       (cdb_wa),
    .cdb_wdata    (cdb_wdata),
    .cdb_robid    (cdb_robid),
    .cdb_grant    (cdb_grant)
  );

  always #5 clk = ~clk;

  // Each call advances to just after the next rising edge (start of a new cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic v, input logic [4:0] tag,
                       input logic [4:0] wa, input logic [31:0] data, input logic [4:0] robid);
    fu_res_vld[u]           = v;
    fu_res_tag[u*5 +: 5]    = tag;
    fu_res_wa[u*5 +: 5]     = wa;
    fu_res_wdata[u*32 +: 32] = data;
    fu_res_robid[u*5 +: 5]  = robid;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    flush      = 1'b0;
    fu_res_vld = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    flush        = 1'b0;
    fu_res_vld   = '0;
    fu_res_tag   = '0;
    fu_res_wa    = '0;
    fu_res_wdata = '0;
    fu_res_robid = '0;
    step();
    n_checks++;
    if ({cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid});
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (fu_res_rdy !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b expected 111", fu_res_rdy);
    end
    n_checks++;
    if ({cdb_vld, cdb_grant} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: got vld=%b grant=%b expected 0/000", cdb_vld, cdb_grant);
    end
  endtask

  task automatic test_single();
    drive(1, 1'b1, 5'd3, 5'd7, 32'hDEADBEEF, 5'd9);
    step();
    fu_res_vld = '0;
    n_checks++;
    if ({cdb_vld, cdb_grant} !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_c1: got vld=%b grant=%b expected 0/000", cdb_vld, cdb_grant);
    end
    step();
    n_checks++;
    if ({cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid} !==
        {1'b1, 3'b010, 5'd3, 5'd7, 32'hDEADBEEF, 5'd9}) begin
      n_fail++;
      $display("FAIL single_c2: got vld=%b grant=%b tag=%0d wa=%0d data=%h robid=%0d expected 1/010/3/7/deadbeef/9",
               cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid);
    end
    step();
    n_checks++;
    if ({cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid} !==
        {1'b0, 3'b000, 5'd3, 5'd7, 32'hDEADBEEF, 5'd9}) begin
      n_fail++;
      $display("FAIL single_c3: got vld=%b grant=%b tag=%0d data=%h expected 0/000 with fields held",
               cdb_vld, cdb_grant, cdb_tag, cdb_wdata);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_g;
    do_reset();
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(u + 1), 5'(u + 4), 32'(u + 100), 5'(u + 20));
    step();
    fu_res_vld = '0;
    n_checks++;
    if (cdb_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_c1: got vld=%b expected 0", cdb_vld);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      exp_g = 3'(1 << k);
      n_checks++;
      if ({cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid} !==
          {1'b1, exp_g, 5'(k + 1), 5'(k + 4), 32'(k + 100), 5'(k + 20)}) begin
        n_fail++;
        $display("FAIL simul_c%0d: got vld=%b grant=%b tag=%0d wa=%0d data=%0d robid=%0d expected 1/%b/%0d/%0d/%0d/%0d",
                 k + 2, cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid,
                 exp_g, k + 1, k + 4, k + 100, k + 20);
      end
    end
    step();
    n_checks++;
    if ({cdb_vld, cdb_grant} !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_end: got vld=%b grant=%b expected 0/000", cdb_vld, cdb_grant);
    end
  endtask

  // Occupancy is accepted minus broadcast results, which gives the required rdy.
  task automatic test_fairness();
    int acc[3];
    int bcast[3];
    int g30[3];
    int bcount;
    int exp_u;
    int u;
    int occ;
    logic [2:0] rdy_s;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0; bcast[i] = 0; g30[i] = 0;
    end
    bcount = 0;
    exp_u  = 0;
    for (int c = 0; c < 45; c++) begin
      if (cdb_vld === 1'b1) begin
        case (cdb_grant)
          3'b001:  u = 0;
          3'b010:  u = 1;
          3'b100:  u = 2;
          default: u = -1;
        endcase
        n_checks++;
        if (u < 0) begin
          n_fail++;
          $display("FAIL fair_onehot: cycle %0d got grant=%b expected one-hot", c, cdb_grant);
        end else begin
          if (bcount < 30) begin
            n_checks++;
            if (u != exp_u) begin
              n_fail++;
              $display("FAIL fair_rotation: cycle %0d got unit %0d expected unit %0d", c, u, exp_u);
            end
            g30[u]++;
            exp_u = (u + 1) % 3;
          end
          n_checks++;
          if ({cdb_tag, cdb_wa, cdb_wdata} !== {5'(bcast[u]), 5'(u), 32'(u * 256 + bcast[u])}) begin
            n_fail++;
            $display("FAIL fair_order: cycle %0d unit %0d got tag=%0d wa=%0d data=%0d expected %0d/%0d/%0d",
                     c, u, cdb_tag, cdb_wa, cdb_wdata, bcast[u], u, u * 256 + bcast[u]);
          end
          bcast[u]++;
        end
        bcount++;
      end
      for (int i = 0; i < 3; i++) begin
        occ = acc[i] - bcast[i];
        n_checks++;
        if (fu_res_rdy[i] !== (occ != 2)) begin
          n_fail++;
          $display("FAIL fair_rdy: cycle %0d unit %0d got rdy=%b expected %b (occupancy %0d)",
                   c, i, fu_res_rdy[i], occ != 2, occ);
        end
      end
      for (int i = 0; i < 3; i++) drive(i, (c < 30), 5'(acc[i]), 5'(i), 32'(i * 256 + acc[i]), 5'd0);
      rdy_s = fu_res_rdy;
      step();
      for (int i = 0; i < 3; i++) if (fu_res_vld[i] && rdy_s[i]) acc[i]++;
    end
    fu_res_vld = '0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (g30[i] != 10) begin
        n_fail++;
        $display("FAIL fair_share: unit %0d got %0d of first 30 grants expected 10", i, g30[i]);
      end
      n_checks++;
      if (bcast[i] != acc[i]) begin
        n_fail++;
        $display("FAIL fair_lossless: unit %0d got %0d broadcasts expected %0d accepted", i, bcast[i], acc[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_g [4];
    logic [4:0] exp_t [4];
    exp_g[0] = 3'b001; exp_t[0] = 5'd10;
    exp_g[1] = 3'b100; exp_t[1] = 5'd20;
    exp_g[2] = 3'b001; exp_t[2] = 5'd11;
    exp_g[3] = 3'b100; exp_t[3] = 5'd21;
    do_reset();
    drive(2, 1'b1, 5'd5, 5'd0, 32'd0, 5'd0);
    step();
    fu_res_vld = '0;
    step();
    n_checks++;
    if ({cdb_vld, cdb_grant, cdb_tag} !== {1'b1, 3'b100, 5'd5}) begin
      n_fail++;
      $display("FAIL wrap_first: got vld=%b grant=%b tag=%0d expected 1/100/5", cdb_vld, cdb_grant, cdb_tag);
    end
    drive(0, 1'b1, 5'd10, 5'd0, 32'd0, 5'd0);
    drive(2, 1'b1, 5'd20, 5'd0, 32'd0, 5'd0);
    step();
    drive(0, 1'b1, 5'd11, 5'd0, 32'd0, 5'd0);
    drive(2, 1'b1, 5'd21, 5'd0, 32'd0, 5'd0);
    step();
    fu_res_vld = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({cdb_vld, cdb_grant, cdb_tag} !== {1'b1, exp_g[k], exp_t[k]}) begin
        n_fail++;
        $display("FAIL wrap_seq%0d: got vld=%b grant=%b tag=%0d expected 1/%b/%0d",
                 k, cdb_vld, cdb_grant, cdb_tag, exp_g[k], exp_t[k]);
      end
      step();
    end
    n_checks++;
    if (cdb_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end: got vld=%b expected 0", cdb_vld);
    end
  endtask

  task automatic test_flush();
    logic [2:0] exp_g [3];
    exp_g[0] = 3'b100; exp_g[1] = 3'b001; exp_g[2] = 3'b010;
    do_reset();
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(u + 8), 5'd0, 32'd0, 5'd0);
    step();
    step();
    n_checks++;
    if (cdb_grant !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_pre0: got grant=%b expected 001", cdb_grant);
    end
    step();
    n_checks++;
    if (cdb_grant !== 3'b010) begin
      n_fail++;
      $display("FAIL flush_pre1: got grant=%b expected 010", cdb_grant);
    end
    flush = 1'b1;
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(u + 29), 5'd0, 32'd0, 5'd0);
    step();
    flush      = 1'b0;
    fu_res_vld = '0;
    n_checks++;
    if ({cdb_vld, cdb_grant, fu_res_rdy} !== {1'b0, 3'b000, 3'b111}) begin
      n_fail++;
      $display("FAIL flush_next: got vld=%b grant=%b rdy=%b expected 0/000/111", cdb_vld, cdb_grant, fu_res_rdy);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (cdb_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_quiet: got vld=%b tag=%0d expected no broadcast", cdb_vld, cdb_tag);
      end
    end
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(u + 1), 5'd0, 32'd0, 5'd0);
    step();
    fu_res_vld = '0;
    step();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({cdb_vld, cdb_grant} !== {1'b1, exp_g[k]}) begin
        n_fail++;
        $display("FAIL flush_rrkept%0d: got vld=%b grant=%b expected 1/%b", k, cdb_vld, cdb_grant, exp_g[k]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(u + 11), 5'd1, 32'd5, 5'd2);
    step();
    step();
    n_checks++;
    if ({cdb_vld, cdb_grant, cdb_tag} !== {1'b1, 3'b100, 5'd13}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got vld=%b grant=%b tag=%0d expected 1/100/13", cdb_vld, cdb_grant, cdb_tag);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid, fu_res_rdy} !== {51'd0, 3'b111}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got vld=%b grant=%b tag=%0d wa=%0d data=%0d robid=%0d rdy=%b expected all 0, rdy 111",
               cdb_vld, cdb_grant, cdb_tag, cdb_wa, cdb_wdata, cdb_robid, fu_res_rdy);
    end
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(u + 7), 5'd0, 32'd0, 5'd0);
    step();
    fu_res_vld = '0;
    n_checks++;
    if (cdb_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale: got vld=%b tag=%0d expected no broadcast", cdb_vld, cdb_tag);
    end
    step();
    n_checks++;
    if ({cdb_vld, cdb_grant, cdb_tag} !== {1'b1, 3'b001, 5'd7}) begin
      n_fail++;
      $display("FAIL rstmid_first: got vld=%b grant=%b tag=%0d expected 1/001/7", cdb_vld, cdb_grant, cdb_tag);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
